// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issues operand pairs to an external pipelined multiplier,
// tracks them with a valid/tag pipe matched to the multiplier depth, and
// buffers the products in a small FIFO. Credit-based admission (buffered +
// in flight < depth) guarantees every issued product has a FIFO slot.
module mult_issue_ctrl #(
  parameter int DATA_LEN     = 32,
  parameter int TAG_LEN      = 8,
  parameter int MULT_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_LEN-1:0]                 in_a,
  input  logic [DATA_LEN-1:0]                 in_b,
  input  logic [TAG_LEN-1:0]                  in_tag,
  output logic [DATA_LEN-1:0]                 mul_a,
  output logic [DATA_LEN-1:0]                 mul_b,
  input  logic [DATA_LEN-1:0]                 mul_result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_LEN-1:0]                 out_result,
  output logic [TAG_LEN-1:0]                  out_tag,
  output logic [$clog2(MULT_LATENCY+2):0]     inflight,
  output logic                                busy
);

  localparam int PIPE_LEN = MULT_LATENCY + 1;
  localparam int INF_W    = $clog2(MULT_LATENCY + 2) + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int OCC_W    = CNT_W + INF_W;

  logic                               accept;
  logic [DATA_LEN-1:0]                mul_a_q, mul_a_d;
  logic [DATA_LEN-1:0]                mul_b_q, mul_b_d;
  logic [PIPE_LEN-1:0]                vld_q, vld_d;
  logic [PIPE_LEN-1:0][TAG_LEN-1:0]   tag_q, tag_d;
  logic [INF_W-1:0]                   inflight_c;
  logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic [OCC_W-1:0]                   occupancy;
  logic                               wr_en;
  logic                               rd_en;
  logic                               fifo_full;
  logic [DATA_LEN-1:0]                res_mem [FIFO_DEPTH];
  logic [TAG_LEN-1:0]                 tag_mem [FIFO_DEPTH];

  // Admission uses registered state only, so the consumer side never
  // reaches combinationally into the producer handshake.
  assign occupancy = {{INF_W{1'b0}}, count_q} + {{CNT_W{1'b0}}, inflight_c};
  assign in_ready  = occupancy < OCC_W'(FIFO_DEPTH);
  assign accept    = in_valid && in_ready;

  // The top of the valid pipe lines up with the multiplier output.
  assign wr_en     = vld_q[PIPE_LEN-1];
  assign rd_en     = out_valid && out_ready;
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign out_valid  = (count_q != '0);
  assign out_result = res_mem[rd_ptr_q];
  assign out_tag    = tag_mem[rd_ptr_q];
  assign inflight   = inflight_c;
  assign busy       = (inflight_c != '0) || (count_q != '0);

  // Operand registers load only on accept; tracking pipe shifts every cycle.
  always_comb begin
    mul_a_d = accept ? in_a : mul_a_q;
    mul_b_d = accept ? in_b : mul_b_q;
    vld_d   = {vld_q[PIPE_LEN-2:0], accept};
    tag_d   = {tag_q[PIPE_LEN-2:0], in_tag};
  end

  // Number of operations issued whose products are not yet in the FIFO.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < PIPE_LEN; i++) begin
      inflight_c = inflight_c + INF_W'(vld_q[i]);
    end
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap as power of 2.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag pipe and FIFO storage carry data only; validity lives elsewhere.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    if (wr_en) begin
      res_mem[wr_ptr_q] <= mul_result;
      tag_mem[wr_ptr_q] <= tag_q[PIPE_LEN-1];
    end
  end

  // Admission control must make an overflowing write impossible.
  wr_when_full_a : assert property (@(posedge clk) disable iff (reset)
    !(wr_en && fifo_full && !rd_en));

endmodule

// File: doc/mult_issue_ctrl.md
MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_LEN, 32, operand/result width.
- TAG_LEN, 8, sideband tag width.
- MULT_LATENCY, 1, register stages in the downstream multiplier (>=1).
- FIFO_DEPTH, 4, result buffer entries (power of 2, >=2).
REQ-002 Ports (name direction width meaning):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block accepts operand pair this cycle.
- in_a  in  DATA_LEN  operand A, two's complement.
- in_b  in  DATA_LEN  operand B, two's complement.
- in_tag  in  TAG_LEN  tag returned with the result.
- mul_a  out  DATA_LEN  registered operand A to the multiplier.
- mul_b  out  DATA_LEN  registered operand B to the multiplier.
- mul_result  in  DATA_LEN  multiplier product, low DATA_LEN bits.
- out_valid  out  1  result available at FIFO head.
- out_ready  in  1  consumer takes the result.
- out_result  out  DATA_LEN  product at FIFO head.
- out_tag  out  TAG_LEN  tag at FIFO head.
- inflight  out  $clog2(MULT_LATENCY+2)+1  operations issued but not yet buffered.
- busy  out  1  inflight!=0 or FIFO not empty.

Function
REQ-003 Accept occurs on a rising edge where in_valid && in_ready.
REQ-004 in_ready SHALL be (fifo_count + inflight) < FIFO_DEPTH; it is combinational from registered state only, with no out_ready lookahead.
REQ-005 On accept, mul_a/mul_b SHALL load in_a/in_b; otherwise mul_a/mul_b hold their values.
REQ-006 The valid pipe is MULT_LATENCY+1 bits; bit 0 is loaded with the accept strobe, and the pipe shifts every cycle, never stalling.
REQ-007 The tag pipe parallels the valid pipe; stages whose valid bit is 0 are don't-care.
REQ-008 When the top valid bit is 1 at an edge, mul_result and the top tag SHALL be written to the FIFO tail.
REQ-009 Accept-to-out_valid latency SHALL be MULT_LATENCY+2 edges when the FIFO is empty (3 at default).
REQ-010 inflight SHALL equal the popcount of the valid pipe.
REQ-011 out_valid = FIFO not empty; out_result/out_tag = FIFO head; pop on out_valid && out_ready.
REQ-012 A simultaneous FIFO write and pop SHALL leave fifo_count unchanged; write to an empty FIFO while popping is not possible, because pop requires out_valid.
REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH; REQ-004 guarantees no write when full, and an assertion SHALL flag write-when-full.
REQ-014 Results SHALL leave in strict acceptance order.
REQ-015 Product values are produced by the multiplier; this block neither modifies nor sign-extends them.
REQ-016 out_result/out_tag SHALL hold stable while out_valid && !out_ready.

Reset
REQ-017 When reset is high at an edge: valid pipe, FIFO pointers, and fifo_count cleared; mul_a, mul_b = 0.
REQ-018 Outputs after reset: in_ready=1, out_valid=0, inflight=0, busy=0, out_result/out_tag=don't-care.
REQ-019 Reset mid-operation SHALL discard all in-flight and buffered results; none appear after reset.
REQ-020 The multiplier SHALL share the same reset.

Verification
REQ-021 Single op: a=3, b=-5, tag=0x11, out_ready=1 -> out_valid 3 edges after accept with out_result=0xFFFFFFF1, out_tag=0x11.
REQ-022 Truncation: a=0x00010000, b=0x00010000 -> out_result=0x00000000.
REQ-023 Backpressure: out_ready=0, in_valid=1 continuously -> exactly 4 accepts, in_ready=0 after the 4th accept, 4 results buffered, busy=1. Then out_ready=1 -> results drain in order, and in_ready reasserts the cycle after the first pop.
REQ-024 Streaming: in_valid=1 and out_ready=1 for 20 cycles, operands i and i+1 -> one accept per cycle sustained, outputs i*(i+1) in order with no drops.
REQ-025 Reset mid-flight: 2 ops accepted, then reset on the next edge -> out_valid stays 0 for 5 cycles after reset, and inflight=0.
REQ-026 Random: random in_valid/out_ready for 10k cycles vs a reference queue model -> zero mismatches, and the write-when-full assertion never fires.
